// File: rtl/qos_rd_scheduler.sv
// qos_rd_scheduler
//   Drains four upstream virtual-channel FIFOs into one downstream FIFO.
//   Urgent VCs (upstream almost_full) are served before normal VCs, with
//   round-robin inside whichever class is chosen. A popped word comes back on
//   vc_data one cycle after the pop, is captured, and is forwarded with its VC
//   tag two cycles after the pop. A two-entry skid buffer absorbs words that
//   land while the downstream FIFO reports full.
//
// Ports
//   clk             clock, all state on posedge
//   reset           asynchronous, active-low (0 = in reset)
//   vc_empty        per-VC empty flag
//   vc_almost_full  per-VC almost_full flag; marks the VC urgent
//   vc_data         VCi word on [i*DATA_W +: DATA_W], valid the cycle after pop
//   ds_almost_full  downstream almost_full
//   ds_full         downstream full
//   pop             one-hot fifo_rd to the upstream VC FIFOs
//   data_out        forwarded word
//   vc_id_out       source VC of data_out
//   valid_out       downstream fifo_wr
//   sched_state     FSM state (IDLE=00, ACTIVE=01, PAUSE=10)
module qos_rd_scheduler #(
  parameter int DATA_W = 6,
  parameter int NUM_VC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic [NUM_VC-1:0]        vc_almost_full,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  input  logic                     ds_almost_full,
  input  logic                     ds_full,
  output logic [NUM_VC-1:0]        pop,
  output logic [DATA_W-1:0]        data_out,
  output logic [1:0]               vc_id_out,
  output logic                     valid_out,
  output logic [1:0]               sched_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    PAUSE  = 2'b10
  } state_t;

  state_t              state;
  logic [1:0]          rr_ptr;

  logic [NUM_VC-1:0]   eligible;
  logic [NUM_VC-1:0]   urgent;
  logic [NUM_VC-1:0]   cand;
  logic [1:0]          scan_idx;
  logic [1:0]          grant_idx;
  logic                grant_vld;
  logic                pop_ok;

  logic                vld_p0;
  logic [1:0]          vc_p0;
  logic                vld_p1;
  logic [1:0]          vc_p1;
  logic [DATA_W-1:0]   data_p1;
  logic [DATA_W+1:0]   word_p1;

  logic [1:0]          skid_cnt;
  logic [DATA_W+1:0]   skid_0;
  logic [DATA_W+1:0]   skid_1;
  logic                skid_push;
  logic                skid_pop;

  // Grant: urgent class wins outright, round-robin from rr_ptr within a class.
  always_comb begin
    eligible  = ~vc_empty;
    urgent    = eligible & vc_almost_full;
    cand      = (|urgent) ? urgent : eligible;
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    scan_idx  = rr_ptr;
    for (int k = 0; k < NUM_VC; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (!grant_vld && cand[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // IDLE may pop in the very cycle data appears. Pops also wait for the skid
  // buffer to drain, which bounds held plus in-flight words to two.
  always_comb begin
    pop_ok = reset & ~ds_almost_full & ~ds_full & (skid_cnt == 2'd0) &
             ((state == ACTIVE) | ((state == IDLE) & (|eligible)));
    pop = '0;
    if (pop_ok && grant_vld) pop[grant_idx] = 1'b1;
  end

  assign skid_pop  = ~ds_full & (skid_cnt != 2'd0);
  assign skid_push = vld_p1 & (ds_full | (skid_cnt != 2'd0));
  assign word_p1   = {vc_p1, data_p1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      vld_p0   <= 1'b0;
      vc_p0    <= 2'd0;
      vld_p1   <= 1'b0;
      vc_p1    <= 2'd0;
      data_p1  <= '0;
      skid_cnt <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ds_almost_full)  state <= PAUSE;
          else if (|eligible)  state <= ACTIVE;
        end
        ACTIVE: begin
          if (ds_almost_full || ds_full) state <= PAUSE;
          else if (!(|eligible))         state <= IDLE;
        end
        PAUSE: begin
          if (!ds_almost_full && !ds_full) state <= (|eligible) ? ACTIVE : IDLE;
        end
        default: state <= IDLE;
      endcase

      if (|pop) rr_ptr <= grant_idx + 2'd1;

      // ---- stage p0: pop issued, upstream word returns next cycle ----
      vld_p0 <= |pop;
      vc_p0  <= grant_idx;

      // ---- stage p1: capture the returned word with its VC tag ----
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        vc_p1   <= vc_p0;
        data_p1 <= vc_data[int'(vc_p0)*DATA_W +: DATA_W];
      end

      unique case ({skid_push, skid_pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  // ---- stage p2: skid buffer, oldest held word always emits first ----
  always_ff @(posedge clk) begin
    if (skid_pop) begin
      if (skid_push) begin
        if (skid_cnt == 2'd2) begin
          skid_0 <= skid_1;
          skid_1 <= word_p1;
        end else begin
          skid_0 <= word_p1;
        end
      end else begin
        skid_0 <= skid_1;
      end
    end else if (skid_push) begin
      if (skid_cnt == 2'd0) skid_0 <= word_p1;
      else                  skid_1 <= word_p1;
    end
  end

  always_comb begin
    if (skid_cnt != 2'd0) {vc_id_out, data_out} = skid_0;
    else                  {vc_id_out, data_out} = word_p1;
    valid_out = ~ds_full & ((skid_cnt != 2'd0) | vld_p1);
  end

  assign sched_state = state;

endmodule

// File: tb/tb_qos_rd_scheduler.sv
module tb_qos_rd_scheduler;
  localparam int DW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [3:0]    vc_empty;
  logic [3:0]    vc_almost_full;
  logic [4*DW-1:0] vc_data;
  logic          ds_almost_full;
  logic          ds_full;
  logic [3:0]    pop;
  logic [DW-1:0] data_out;
  logic [1:0]    vc_id_out;
  logic          valid_out;
  logic [1:0]    sched_state;

  qos_rd_scheduler #(.DATA_W(DW), .NUM_VC(4)) dut (
    .clk(clk), .reset(reset), .vc_empty(vc_empty), .vc_almost_full(vc_almost_full),
    .vc_data(vc_data), .ds_almost_full(ds_almost_full), .ds_full(ds_full),
    .pop(pop), .data_out(data_out), .vc_id_out(vc_id_out), .valid_out(valid_out),
    .sched_state(sched_state)
  );

  // Upstream FIFO contents and the expected output stream (word + cycle it is due).
  logic [DW-1:0] fifo [4][$];
  typedef struct { logic [DW-1:0] d; logic [1:0] vc; int rdy; } word_t;
  word_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_state = 0;   // 0 idle, 1 active, 2 pause
  int m_ptr   = 0;
  logic [DW-1:0] nd = '0;

  logic [3:0]    e_pop;
  logic          e_vld;
  logic [DW-1:0] e_data;
  logic [1:0]    e_vc;

  function automatic logic [3:0] elig_f();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (fifo[i].size() > 0);
    return r;
  endfunction

  function automatic bit idle_f();
    return (elig_f() == 4'd0) && (exp_q.size() == 0) && (m_state == 0);
  endfunction

  task automatic push_word(input int i);
    fifo[i].push_back(nd);
    nd = nd + 1'b1;
    vc_empty[i] = 1'b0;
  endtask

  // Expected pop and output for the current cycle, from the scheduling rules.
  function automatic void compute_exp();
    logic [3:0] el, ur, st;
    int overdue, idx;
    bit found;
    el = elig_f();
    ur = el & vc_almost_full;
    st = (ur != 4'd0) ? ur : el;
    overdue = 0;
    foreach (exp_q[k]) if (exp_q[k].rdy < cyc) overdue++;
    e_pop = 4'd0;
    found = 1'b0;
    if (reset === 1'b1 && !ds_almost_full && !ds_full && overdue == 0 &&
        (m_state == 1 || (m_state == 0 && el != 4'd0))) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (!found && st[idx]) begin
          found = 1'b1;
          e_pop[idx] = 1'b1;
        end
      end
    end
    e_vld = 1'b0; e_data = '0; e_vc = 2'd0;
    if (reset === 1'b1 && !ds_full && exp_q.size() > 0 && exp_q[0].rdy <= cyc) begin
      e_vld  = 1'b1;
      e_data = exp_q[0].d;
      e_vc   = exp_q[0].vc;
    end
  endfunction

  // Clock edge: move upstream FIFOs and the model forward by one cycle.
  task automatic advance();
    logic [3:0] el;
    word_t w;
    el = elig_f();
    @(posedge clk);
    #1;
    if (!reset) begin
      m_state = 0; m_ptr = 0; exp_q.delete();
    end else begin
      if (e_vld) void'(exp_q.pop_front());
      for (int g = 0; g < 4; g++) begin
        if (e_pop[g]) begin
          w.d = fifo[g].pop_front();
          w.vc = 2'(g);
          w.rdy = cyc + 2;
          exp_q.push_back(w);
          vc_data[g*DW +: DW] = w.d;
          m_ptr = (g + 1) % 4;
        end
      end
      case (m_state)
        0: if (ds_almost_full) m_state = 2; else if (el != 4'd0) m_state = 1;
        1: if (ds_almost_full || ds_full) m_state = 2; else if (el == 4'd0) m_state = 0;
        default: if (!ds_almost_full && !ds_full) m_state = (el != 4'd0) ? 1 : 0;
      endcase
    end
    cyc++;
    for (int i = 0; i < 4; i++) vc_empty[i] = (fifo[i].size() == 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; vc_almost_full = 4'd0; ds_almost_full = 1'b0; ds_full = 1'b0;
    vc_data = '0; vc_empty = 4'hF;
    for (int i = 0; i < 4; i++) repeat (3) push_word(i);
    repeat (3) begin
      @(negedge clk);
      compute_exp();
      total++; if (pop !== 4'b0000) begin bad++; $display("FAIL reset_pop got=%b exp=0000", pop); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      total++; if (sched_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", sched_state); end
      total++; if ({vc_id_out, data_out} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", {vc_id_out, data_out}); end
      advance();
    end
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bit done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      compute_exp();
      if (c < 5) begin
        total++; if (pop !== rr_seq[c]) begin bad++; $display("FAIL rr_seq c=%0d got=%b exp=%b", c, pop, rr_seq[c]); end
      end
      if (c >= 2 && c <= 6) begin
        total++;
        if (valid_out !== 1'b1 || vc_id_out !== 2'((c - 2) % 4)) begin
          bad++; $display("FAIL rr_vcid c=%0d got=%b/%0d exp=1/%0d", c, valid_out, vc_id_out, (c - 2) % 4);
        end
      end
      total++; if (pop !== e_pop) begin bad++; $display("FAIL rr_pop cyc=%0d got=%b exp=%b", cyc, pop, e_pop); end
      total++; if (sched_state !== 2'(m_state)) begin bad++; $display("FAIL rr_state cyc=%0d got=%0d exp=%0d", cyc, sched_state, m_state); end
      total++; if (valid_out !== e_vld) begin bad++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", cyc, valid_out, e_vld); end
      if (e_vld) begin
        total++;
        if (data_out !== e_data || vc_id_out !== e_vc) begin
          bad++; $display("FAIL rr_word cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, vc_id_out, data_out, e_vc, e_data);
        end
      end
      advance();
      if (c >= 8 && idle_f() && sched_state == 2'b00) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL rr_timeout state=%b exp=00", sched_state); end
  endtask

  task automatic test_urgent();
    bit done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) push_word(0);
      if (c == 1) begin
        push_word(1); push_word(1); push_word(3);
        vc_almost_full = 4'b1000;
      end
      if (c == 3) vc_almost_full = 4'b0000;
      @(negedge clk);
      compute_exp();
      if (c == 1) begin
        total++; if (pop !== 4'b1000) begin bad++; $display("FAIL urg_first got=%b exp=1000", pop); end
      end
      if (c == 2) begin
        total++; if (pop !== 4'b0010) begin bad++; $display("FAIL urg_second got=%b exp=0010", pop); end
      end
      total++; if (pop !== e_pop) begin bad++; $display("FAIL urg_pop cyc=%0d got=%b exp=%b", cyc, pop, e_pop); end
      total++; if (sched_state !== 2'(m_state)) begin bad++; $display("FAIL urg_state cyc=%0d got=%0d exp=%0d", cyc, sched_state, m_state); end
      total++; if (valid_out !== e_vld) begin bad++; $display("FAIL urg_valid cyc=%0d got=%b exp=%b", cyc, valid_out, e_vld); end
      if (e_vld) begin
        total++;
        if (data_out !== e_data || vc_id_out !== e_vc) begin
          bad++; $display("FAIL urg_word cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, vc_id_out, data_out, e_vc, e_data);
        end
      end
      advance();
      if (c >= 4 && idle_f() && sched_state == 2'b00) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL urg_timeout state=%b exp=00", sched_state); end
  endtask

  task automatic test_single_word();
    bit done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) push_word(2);
      @(negedge clk);
      compute_exp();
      if (c == 0) begin
        total++; if (pop !== 4'b0100) begin bad++; $display("FAIL single_pop got=%b exp=0100", pop); end
      end
      if (c == 1) begin
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL single_nopop got=%b exp=0000", pop); end
      end
      if (c == 2) begin
        total++; if (sched_state !== 2'b00) begin bad++; $display("FAIL single_idle got=%b exp=00", sched_state); end
      end
      total++; if (pop !== e_pop) begin bad++; $display("FAIL single_mpop cyc=%0d got=%b exp=%b", cyc, pop, e_pop); end
      total++; if (valid_out !== e_vld) begin bad++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", cyc, valid_out, e_vld); end
      if (e_vld) begin
        total++;
        if (data_out !== e_data || vc_id_out !== e_vc) begin
          bad++; $display("FAIL single_word cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, vc_id_out, data_out, e_vc, e_data);
        end
      end
      advance();
      if (c >= 3 && idle_f() && sched_state == 2'b00) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL single_timeout state=%b exp=00", sched_state); end
  endtask

  task automatic test_almost_full();
    bit done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) repeat (6) push_word(0);
      if (c == 2) ds_almost_full = 1'b1;
      if (c == 6) ds_almost_full = 1'b0;
      @(negedge clk);
      compute_exp();
      if (c == 2) begin
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL af_stop got=%b exp=0000", pop); end
      end
      if (c == 3) begin
        total++; if (sched_state !== 2'b10) begin bad++; $display("FAIL af_pause got=%b exp=10", sched_state); end
      end
      if (c == 2 || c == 3) begin
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL af_inflight c=%0d got=%b exp=1", c, valid_out); end
      end
      if (c == 7) begin
        total++; if (pop !== 4'b0001) begin bad++; $display("FAIL af_resume got=%b exp=0001", pop); end
      end
      total++; if (pop !== e_pop) begin bad++; $display("FAIL af_pop cyc=%0d got=%b exp=%b", cyc, pop, e_pop); end
      total++; if (sched_state !== 2'(m_state)) begin bad++; $display("FAIL af_state cyc=%0d got=%0d exp=%0d", cyc, sched_state, m_state); end
      total++; if (valid_out !== e_vld) begin bad++; $display("FAIL af_valid cyc=%0d got=%b exp=%b", cyc, valid_out, e_vld); end
      if (e_vld) begin
        total++;
        if (data_out !== e_data || vc_id_out !== e_vc) begin
          bad++; $display("FAIL af_word cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, vc_id_out, data_out, e_vc, e_data);
        end
      end
      advance();
      if (c >= 8 && idle_f() && sched_state == 2'b00) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL af_timeout state=%b exp=00", sched_state); end
  endtask

  task automatic test_full_skid();
    bit done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) begin
        nd = 6'd5;
        push_word(1); push_word(1);
      end
      if (c == 2) begin ds_full = 1'b1; ds_almost_full = 1'b1; end
      if (c == 5) begin ds_full = 1'b0; ds_almost_full = 1'b0; end
      @(negedge clk);
      compute_exp();
      if (c >= 2 && c <= 4) begin
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL full_hold c=%0d got=%b exp=0", c, valid_out); end
      end
      if (c == 5 || c == 6) begin
        total++;
        if (valid_out !== 1'b1 || data_out !== DW'(c) || vc_id_out !== 2'd1) begin
          bad++; $display("FAIL full_order c=%0d got=%b/%0d/%0d exp=1/1/%0d", c, valid_out, vc_id_out, data_out, c);
        end
      end
      total++; if (pop !== e_pop) begin bad++; $display("FAIL full_pop cyc=%0d got=%b exp=%b", cyc, pop, e_pop); end
      total++; if (sched_state !== 2'(m_state)) begin bad++; $display("FAIL full_state cyc=%0d got=%0d exp=%0d", cyc, sched_state, m_state); end
      total++; if (valid_out !== e_vld) begin bad++; $display("FAIL full_valid cyc=%0d got=%b exp=%b", cyc, valid_out, e_vld); end
      advance();
      if (c >= 7 && idle_f() && sched_state == 2'b00) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL full_timeout state=%b exp=00", sched_state); end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    for (int c = 0; c < 480; c++) begin
      if (c < 400) begin
        for (int i = 0; i < 4; i++)
          if (fifo[i].size() < 6 && $urandom_range(0, 2) == 0) push_word(i);
        vc_almost_full = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        ds_almost_full = ($urandom_range(0, 7) == 0);
        ds_full        = ($urandom_range(0, 11) == 0);
      end else begin
        vc_almost_full = 4'd0; ds_almost_full = 1'b0; ds_full = 1'b0;
      end
      @(negedge clk);
      compute_exp();
      total++; if (pop !== e_pop) begin bad++; $display("FAIL rnd_pop cyc=%0d got=%b exp=%b", cyc, pop, e_pop); end
      total++; if (sched_state !== 2'(m_state)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, sched_state, m_state); end
      total++; if (valid_out !== e_vld) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid_out, e_vld); end
      if (e_vld) begin
        total++;
        if (data_out !== e_data || vc_id_out !== e_vc) begin
          bad++; $display("FAIL rnd_word cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, vc_id_out, data_out, e_vc, e_data);
        end
      end
      advance();
      if (c >= 400 && idle_f() && sched_state == 2'b00) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL rnd_timeout state=%b exp=00", sched_state); end
  endtask

  task automatic test_reset_mid();
    bit done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0) for (int i = 0; i < 4; i++) repeat (3) push_word(i);
      if (c == 4) begin
        reset = 1'b0;
        m_state = 0; m_ptr = 0; exp_q.delete();
        #1;
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL mid_pop got=%b exp=0000", pop); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", valid_out); end
        total++; if (sched_state !== 2'b00) begin bad++; $display("FAIL mid_state got=%b exp=00", sched_state); end
      end
      if (c == 6) reset = 1'b1;
      @(negedge clk);
      compute_exp();
      total++; if (pop !== e_pop) begin bad++; $display("FAIL mid_mpop cyc=%0d got=%b exp=%b", cyc, pop, e_pop); end
      total++; if (sched_state !== 2'(m_state)) begin bad++; $display("FAIL mid_mstate cyc=%0d got=%0d exp=%0d", cyc, sched_state, m_state); end
      total++; if (valid_out !== e_vld) begin bad++; $display("FAIL mid_mvalid cyc=%0d got=%b exp=%b", cyc, valid_out, e_vld); end
      if (e_vld) begin
        total++;
        if (data_out !== e_data || vc_id_out !== e_vc) begin
          bad++; $display("FAIL mid_word cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, vc_id_out, data_out, e_vc, e_data);
        end
      end
      advance();
      if (c >= 7 && idle_f() && sched_state == 2'b00) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL mid_timeout state=%b exp=00", sched_state); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_urgent();
    test_single_word();
    test_almost_full();
    test_full_skid();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
